// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM state encodings
// and status-bit positions, so status decoders elsewhere use the same map.
package uart_tx_fifo_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_e;

   localparam int STA_BUSY = 0;
   localparam int STA_FULL = 1;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush, occupancy level and combinational head read.
// A push while full is accepted only when a pop frees the head slot in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q;
   logic [AW-1:0]    rptr_q;
   logic [LW-1:0]    level_q;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (level_q == LW'(DEPTH));
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign rdata_o = mem_q[rptr_q];

   // Flush wins over both push and pop; the caller may still consume rdata_o.
   assign do_pop  = pop_i & ~empty_o & ~flush_i;
   assign do_push = push_i & ~flush_i & (~full_o | do_pop);

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wptr_q] <= wdata_i;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else if (flush_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + AW'(1);
         if (do_pop)  rptr_q <= rptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   level_q <= level_q + LW'(1);
            2'b01:   level_q <= level_q - LW'(1);
            default: level_q <= level_q;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO of characters serialised LSB first with a
// baud down-timed frame FSM and a sticky overflow flag.
//
// state    | meaning
// ST_IDLE  | line high, pops the head when enabled and FIFO non-empty
// ST_START | start bit (low) for CLK_DIV cycles
// ST_DATA  | DATA_BITS data bits, LSB first, CLK_DIV cycles each
// ST_STOP  | stop bit(s) (high) for STOP_BITS*CLK_DIV cycles
module uart_tx_fifo
   import uart_tx_fifo_pkg::*;
#(
   parameter int CLK_DIV    = 16,
   parameter int FIFO_DEPTH = 8,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1
) (
   input  logic                          clk_i_w,
   input  logic                          rst_i_w,
   input  logic                          en_i_w,
   input  logic                          wr_i_w,
   input  logic [DATA_BITS-1:0]          wdat_i_w,
   input  logic                          flush_i_w,
   input  logic                          clr_ovf_i_w,
   output logic [1:0]                    sta_o_r,
   output logic [$clog2(FIFO_DEPTH):0]   level_o_r,
   output logic                          ovf_o_r,
   output logic                          txd_o_r
);

   localparam int BW = $clog2(CLK_DIV);
   localparam int IW = $clog2(DATA_BITS);

   tx_state_e            state_q;
   logic [BW-1:0]        baud_q;
   logic [IW-1:0]        bit_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 txd_q;
   logic                 ovf_q;
   logic                 ovf_d;

   logic [DATA_BITS-1:0] fifo_rdata;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 pop;
   logic                 bit_end;

   assign pop     = (state_q == ST_IDLE) & en_i_w & ~fifo_empty;
   assign bit_end = (baud_q == BW'(CLK_DIV - 1));

   sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i_w),
      .rst_n_i (rst_i_w),
      .push_i  (wr_i_w),
      .pop_i   (pop),
      .flush_i (flush_i_w),
      .wdata_i (wdat_i_w),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (level_o_r)
   );

   // A dropped push outranks a same-cycle clear so no overflow goes unreported.
   always_comb begin
      ovf_d = ovf_q;
      if (clr_ovf_i_w) ovf_d = 1'b0;
      if (wr_i_w && !flush_i_w && fifo_full && !pop) ovf_d = 1'b1;
   end

   always_ff @(posedge clk_i_w or negedge rst_i_w) begin
      if (!rst_i_w) ovf_q <= 1'b0;
      else          ovf_q <= ovf_d;
   end

   always_ff @(posedge clk_i_w or negedge rst_i_w) begin
      if (!rst_i_w) begin
         state_q <= ST_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         txd_q   <= 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               txd_q <= 1'b1;
               if (pop) begin
                  shift_q <= fifo_rdata;
                  baud_q  <= '0;
                  txd_q   <= 1'b0;
                  state_q <= ST_START;
               end
            end
            ST_START: begin
               if (bit_end) begin
                  baud_q  <= '0;
                  bit_q   <= '0;
                  txd_q   <= shift_q[0];
                  state_q <= ST_DATA;
               end else begin
                  baud_q <= baud_q + BW'(1);
               end
            end
            ST_DATA: begin
               if (bit_end) begin
                  baud_q <= '0;
                  if (bit_q == IW'(DATA_BITS - 1)) begin
                     bit_q   <= '0;
                     txd_q   <= 1'b1;
                     state_q <= ST_STOP;
                  end else begin
                     bit_q   <= bit_q + IW'(1);
                     shift_q <= shift_q >> 1;
                     txd_q   <= shift_q[1];
                  end
               end else begin
                  baud_q <= baud_q + BW'(1);
               end
            end
            ST_STOP: begin
               if (bit_end) begin
                  baud_q <= '0;
                  if (bit_q == IW'(STOP_BITS - 1)) begin
                     bit_q   <= '0;
                     state_q <= ST_IDLE;
                  end else begin
                     bit_q <= bit_q + IW'(1);
                  end
               end else begin
                  baud_q <= baud_q + BW'(1);
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign sta_o_r[STA_BUSY] = (state_q != ST_IDLE) | ~fifo_empty;
   assign sta_o_r[STA_FULL] = fifo_full;
   assign ovf_o_r           = ovf_q;
   assign txd_o_r           = txd_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed stimulus, scoreboard of expected characters
// checked by a line-decoding monitor, plus directed status/timing checks.
module tb_uart_tx_fifo;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       wr = 1'b0;
   logic       flush = 1'b0;
   logic       clr = 1'b0;
   logic [7:0] wdat = 8'h00;
   logic [1:0] sta;
   logic [2:0] level;
   logic       ovf;
   logic       txd;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   logic [7:0] exp_q[$];
   int         starts[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx_fifo #(
      .CLK_DIV    (4),
      .FIFO_DEPTH (4),
      .DATA_BITS  (8),
      .STOP_BITS  (1)
   ) dut (
      .clk_i_w     (clk),
      .rst_i_w     (rst_n),
      .en_i_w      (en),
      .wr_i_w      (wr),
      .wdat_i_w    (wdat),
      .flush_i_w   (flush),
      .clr_ovf_i_w (clr),
      .sta_o_r     (sta),
      .level_o_r   (level),
      .ovf_o_r     (ovf),
      .txd_o_r     (txd)
   );

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic after_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (!(exp_q.size() == 0 && sta == 2'b00) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("drain_within_budget", (n < budget) ? 1 : 0, 1);
   endtask

   // Monitor: decode frames from txd (sampled on falling clock edges) and
   // compare against the scoreboard. Frames overlapped by reset are discarded.
   initial begin
      logic [7:0] data;
      logic       stop_b;
      logic       aborted;
      int         t0;
      forever begin
         @(negedge clk);
         if (rst_n && txd == 1'b0) begin
            t0 = cyc;
            aborted = 1'b0;
            data = 8'h00;
            stop_b = 1'b0;
            for (int k = 1; k <= 37; k++) begin
               @(negedge clk);
               if (!rst_n) aborted = 1'b1;
               if (k >= 5 && k <= 33 && ((k - 5) % 4) == 0) data[(k - 5) / 4] = txd;
               if (k == 37) stop_b = txd;
            end
            if (!aborted) begin
               starts.push_back(t0);
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL frame_unexpected: got char 0x%02h, expected no frame (cycle %0d)", data, cyc);
               end else begin
                  chk("frame_data", int'(data), int'(exp_q.pop_front()));
               end
               chk("frame_stop_bit", int'(stop_b), 1);
            end
         end
      end
   end

   initial begin
      logic [7:0] burst [6];
      logic [7:0] a5;
      int s;
      int expb;
      burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33;
      burst[3] = 8'h44; burst[4] = 8'h55; burst[5] = 8'h66;
      a5 = 8'hA5;

      // Reset and idle
      repeat (3) @(negedge clk);
      chk("rst_txd", int'(txd), 1);
      chk("rst_sta", int'(sta), 0);
      chk("rst_level", int'(level), 0);
      chk("rst_ovf", int'(ovf), 0);
      rst_n = 1'b1;
      en = 1'b1;
      for (int i = 0; i < 100; i++) begin
         after_edge();
         chk("idle_txd", int'(txd), 1);
         chk("idle_sta", int'(sta), 0);
         chk("idle_level", int'(level), 0);
      end

      // Single frame 0xA5, cycle-exact waveform
      @(negedge clk);
      wr = 1'b1; wdat = 8'hA5; exp_q.push_back(8'hA5);
      after_edge();
      wr = 1'b0;
      chk("single_e0_level", int'(level), 1);
      chk("single_e0_txd", int'(txd), 1);
      chk("single_e0_busy", int'(sta), 1);
      for (int k = 0; k < 40; k++) begin
         after_edge();
         s = k / 4;
         if (s == 0)      expb = 0;
         else if (s == 9) expb = 1;
         else             expb = int'(a5[s - 1]);
         chk("single_wave", int'(txd), expb);
         if (k == 39) chk("single_busy_last", int'(sta), 1);
      end
      after_edge();
      chk("single_busy_drop", int'(sta), 0);
      chk("single_txd_idle", int'(txd), 1);

      // Burst with overflow
      starts.delete();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         wr = 1'b1; wdat = burst[i];
         if (i < 5) exp_q.push_back(burst[i]);
         after_edge();
         if (i == 4) begin
            chk("burst_full_level", int'(level), 4);
            chk("burst_full_sta", int'(sta), 3);
            chk("burst_no_ovf_yet", int'(ovf), 0);
         end
         if (i == 5) begin
            chk("burst_ovf_level", int'(level), 4);
            chk("burst_ovf_flag", int'(ovf), 1);
            chk("burst_ovf_sta", int'(sta), 3);
         end
      end
      wr = 1'b0;
      wait_idle(600);
      chk("burst_frame_count", starts.size(), 5);
      if (starts.size() == 5)
         for (int i = 1; i < 5; i++) chk("burst_spacing", starts[i] - starts[i-1], 41);

      // Enable gating
      @(negedge clk);
      en = 1'b0;
      wr = 1'b1; wdat = 8'h5A; exp_q.push_back(8'h5A);
      after_edge();
      wr = 1'b0;
      chk("en_off_level", int'(level), 1);
      repeat (10) after_edge();
      chk("en_off_txd", int'(txd), 1);
      chk("en_off_level_hold", int'(level), 1);
      @(negedge clk);
      en = 1'b1;
      after_edge();
      chk("en_on_start", int'(txd), 0);
      chk("en_on_pop", int'(level), 0);
      repeat (14) after_edge();
      @(negedge clk);
      en = 1'b0;
      wr = 1'b1; wdat = 8'h77;
      after_edge();
      wr = 1'b0;
      repeat (40) after_edge();
      chk("en_drop_no_next", int'(level), 1);
      chk("en_drop_txd", int'(txd), 1);
      chk("en_drop_frame_done", exp_q.size(), 0);
      @(negedge clk);
      flush = 1'b1;
      after_edge();
      flush = 1'b0;
      chk("flush_idle_level", int'(level), 0);
      chk("flush_idle_sta", int'(sta), 0);

      // Flush with push mid-frame
      @(negedge clk);
      en = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         wr = 1'b1; wdat = 8'(i);
         if (i == 1) exp_q.push_back(8'h01);
         after_edge();
         @(negedge clk);
      end
      wr = 1'b0;
      chk("fill_level", int'(level), 4);
      chk("fill_sta", int'(sta), 3);
      repeat (5) after_edge();
      @(negedge clk);
      flush = 1'b1; wr = 1'b1; wdat = 8'h99;
      after_edge();
      flush = 1'b0; wr = 1'b0;
      chk("flush_level", int'(level), 0);
      chk("flush_ovf_unchanged", int'(ovf), 1);
      chk("flush_sta_busy", int'(sta), 1);
      wait_idle(200);
      repeat (60) after_edge();
      chk("flush_no_more_txd", int'(txd), 1);
      chk("flush_no_more_level", int'(level), 0);

      @(negedge clk);
      clr = 1'b1;
      after_edge();
      clr = 1'b0;
      chk("clr_ovf", int'(ovf), 0);

      // Clear vs overflow, then push+pop while full
      @(negedge clk);
      en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wr = 1'b1; wdat = 8'hC1 + 8'(i); exp_q.push_back(8'hC1 + 8'(i));
         after_edge();
         @(negedge clk);
      end
      wr = 1'b1; wdat = 8'hEE; clr = 1'b1;
      after_edge();
      wr = 1'b0; clr = 1'b0;
      chk("clr_vs_ovf_flag", int'(ovf), 1);
      chk("clr_vs_ovf_level", int'(level), 4);
      @(negedge clk);
      clr = 1'b1;
      after_edge();
      clr = 1'b0;
      chk("clr_ovf_again", int'(ovf), 0);
      @(negedge clk);
      en = 1'b1; wr = 1'b1; wdat = 8'hC5; exp_q.push_back(8'hC5);
      after_edge();
      wr = 1'b0;
      chk("pushpop_full_level", int'(level), 4);
      chk("pushpop_full_ovf", int'(ovf), 0);
      chk("pushpop_full_start", int'(txd), 0);
      wait_idle(800);

      // Reset mid-frame
      @(negedge clk);
      wr = 1'b1; wdat = 8'h3C;
      after_edge();
      @(negedge clk);
      wdat = 8'h3D;
      after_edge();
      wr = 1'b0;
      chk("pre_rst_level", int'(level), 1);
      repeat (8) after_edge();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_txd", int'(txd), 1);
      chk("async_rst_level", int'(level), 0);
      chk("async_rst_sta", int'(sta), 0);
      chk("async_rst_ovf", int'(ovf), 0);
      repeat (8) @(negedge clk);
      rst_n = 1'b1;
      repeat (60) after_edge();
      chk("post_rst_txd", int'(txd), 1);
      chk("post_rst_level", int'(level), 0);

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised, buffered UART transmitter for the jlc3 SoC. It is the successor to the single-character send path: the memory controller pushes characters into an internal FIFO through a write strobe, and a baud-timed state machine serialises them onto `txd_o_r` back-to-back. Frame format, bit period and buffer depth are parameters. Status bits and a sticky overflow flag let software poll instead of spinning per character.

## Interface
- `CLK_DIV`, 16: clock cycles per bit, ≥2.
- `FIFO_DEPTH`, 8: FIFO entries, power of 2, ≥2.
- `DATA_BITS`, 8: data bits per frame, 5..9.
- `STOP_BITS`, 1: stop bits, 1 or 2.

Ports:
- `clk_i_w` in 1: single clock; all state changes on its rising edge.
- `rst_i_w` in 1: reset, asynchronous, active-low.
- `en_i_w` in 1: transmit enable; low holds the FSM in IDLE (no new frame starts).
- `wr_i_w` in 1: push strobe, one character per high cycle.
- `wdat_i_w` in DATA_BITS: character to push.
- `flush_i_w` in 1: discard FIFO contents.
- `clr_ovf_i_w` in 1: clear the overflow flag.
- `sta_o_r` out 2: [0] busy (FSM not IDLE or FIFO non-empty), [1] FIFO full.
- `level_o_r` out log2(FIFO_DEPTH)+1: FIFO occupancy.
- `ovf_o_r` out 1: sticky, set when a push is dropped.
- `txd_o_r` out 1: serial line, idle high.

## Operation
- Reset values: `txd_o_r`=1, `sta_o_r`=0, `level_o_r`=0, `ovf_o_r`=0, FSM=IDLE, FIFO empty, baud counter 0.
- **Push:** `wr_i_w` with not full stores `wdat_i_w`. `wr_i_w` while full drops the data and sets `ovf_o_r`.
- **Simultaneous events:**
  - Push and pop in the same cycle while full: both occur and the level is unchanged; no overflow.
  - `clr_ovf_i_w` and an overflowing push in the same cycle: the flag stays set.
- **Flush:** clears the FIFO pointers and level. It does not abort the frame in flight.
  - Flush and push in the same cycle: flush wins, the write is discarded, no overflow.
  - Flush and pop in the same cycle: the FSM still loads the old head entry.
- **FSM states:**
  - **IDLE:** `txd_o_r`=1. If `en_i_w` and the registered level is ≥1: pop the head into the shift register, clear the baud counter, go to START.
  - **START:** `txd_o_r`=0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - **DATA:** `txd_o_r` = shift[0], LSB first. Each bit is held CLK_DIV cycles, then the register shifts right. After DATA_BITS bits, go to STOP.
  - **STOP:** `txd_o_r`=1 for STOP_BITS×CLK_DIV cycles, then go to IDLE.
- Dropping `en_i_w` mid-frame lets the current frame finish; the next frame is not started.
- Baud counter is 0..CLK_DIV-1; it wraps to 0 at each bit boundary.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Level saturates naturally at FIFO_DEPTH.
- Asserting reset mid-frame forces `txd_o_r` high immediately (asynchronous) and loses the FIFO contents.

## Timing
- A push sampled at edge E0 makes the level 1 after E0. The FSM sees non-empty at E1, and `txd_o_r` falls after E1. First start bit begins 2 edges after the write.
- Frame length is exactly (1+DATA_BITS+STOP_BITS)×CLK_DIV cycles.
- Back-to-back: when STOP ends at edge En with the FIFO non-empty, the FSM passes through IDLE for exactly 1 cycle. The next start bit begins after En+1, giving 1 idle-high cycle between frames.
- `sta_o_r`, `level_o_r` and `ovf_o_r` update on the same edge as the event that causes them; all are registered.
- `sta_o_r[0]` falls on the edge that leaves STOP when the FIFO is empty.

## Structure
- Shared include `def.v` holds the FSM state encodings (ST_IDLE, ST_START, ST_DATA, ST_STOP, 2 bits) and the `sta_o_r` bit-index constants, so `mem_ctrl` decodes status identically.
- One sub-module, `sync_fifo`, parametrised by width and depth:
  - Ports: push/pop/flush, full/empty, level.
  - Read data is combinational from the head entry.
  - Reusable for a future receive path.
- The top file holds the FSM, baud counter, bit index, shift register and overflow flag.

## Test plan
All scenarios use CLK_DIV=4, DATA_BITS=8, STOP_BITS=1, FIFO_DEPTH=4.
- **Reset/idle:** release reset with nothing pushed → `txd_o_r`=1, `sta_o_r`=0, `level_o_r`=0 for 100 cycles.
- **Single frame:** push 0xA5 → `txd_o_r` falls 2 edges after the write, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop high. Frame is 40 cycles; `sta_o_r[0]` drops after it.
- **Burst and overflow:** push 0x11,0x22,0x33,0x44,0x55,0x66 on consecutive cycles with `en_i_w`=1.
  - One entry is popped at E1, so exactly 5 are accepted and 0x66 is dropped.
  - `ovf_o_r`=1 and `sta_o_r[1]`=1 while level is 4.
  - Five frames are sent, each separated by 1 idle cycle.
- **Enable gating:** with `en_i_w`=0, push 0x5A → level 1 and `txd_o_r` stays high. Raise `en_i_w` → frame starts 1 edge later. Drop `en_i_w` mid-DATA → frame completes.
- **Flush/conflicts:**
  - Fill with 4 entries and assert `flush_i_w` with `wr_i_w` mid-frame → current frame completes, level 0, no further frames, `ovf_o_r` unchanged.
  - `clr_ovf_i_w` clears the overflow flag.
- **Reset mid-frame:** assert `rst_i_w` low during DATA → `txd_o_r`=1 asynchronously and all outputs return to their reset values.
